// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 key-schedule blocks.
// Holds the key/round-key/round-counter widths, the number of forward steps,
// the 4-bit S-box and its inverse, and the sequencer state encoding.
package present_pkg;

  localparam int unsigned KEY_W     = 80;
  localparam int unsigned RKEY_W    = 64;
  localparam int unsigned RND_W     = 5;
  localparam int unsigned NUM_STEPS = 31;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StEmit
  } state_e;

endpackage

// File: rtl/inv_key_sequencer_if.sv
// Request/response bundle of the inverse key sequencer.
//   start, key     : requester asks for a new sequence with user key K1
//   busy           : sequencer is not idle
//   out_valid/out_ready/out_key/out_round : round-key stream, round 32 down to 1
//   done           : one-cycle pulse after round key 1 is taken
// master = requester/consumer side, slave = sequencer side.
interface inv_key_sequencer_if;
  import present_pkg::*;

  logic              start;
  logic [KEY_W-1:0]  key;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [RKEY_W-1:0] out_key;
  logic [RND_W:0]    out_round;
  logic              done;

  modport master (
    output start, key, out_ready,
    input  busy, out_valid, out_key, out_round, done
  );

  modport slave (
    input  start, key, out_ready,
    output busy, out_valid, out_key, out_round, done
  );

endinterface

// File: rtl/inv_key_schedule.sv
// PRESENT-80 inverse key-schedule step (combinational), undoing key_schedule.
//   x : key register after a forward step with counter i
//   i : 5-bit round counter that forward step used
//   r : key register before that forward step
module inv_key_schedule
  import present_pkg::*;
(
  output logic [KEY_W-1:0] r,
  input  logic [KEY_W-1:0] x,
  input  logic [RND_W-1:0] i
);

  logic [KEY_W-1:0] t;

  // Undo in reverse order: counter xor, S-box, then rotate right by 61.
  always_comb begin
    t         = x;
    t[19:15]  = x[19:15] ^ i;
    t[79:76]  = INV_SBOX[t[79:76]];
    r         = {t[60:0], t[79:61]};
  end

endmodule

// File: rtl/key_schedule.sv
// PRESENT-80 forward key-schedule step (combinational).
//   x : current 80-bit key register
//   i : 5-bit round counter mixed into bits 19:15
//   r : next key register = rotl61, S-box on the top nibble, counter xor
module key_schedule
  import present_pkg::*;
(
  output logic [KEY_W-1:0] r,
  input  logic [KEY_W-1:0] x,
  input  logic [RND_W-1:0] i
);

  logic [KEY_W-1:0] rot;

  always_comb begin
    rot       = {x[18:0], x[79:19]};
    r         = rot;
    r[79:76]  = SBOX[rot[79:76]];
    r[19:15]  = rot[19:15] ^ i;
  end

endmodule

// File: rtl/inv_key_sequencer.sv
// Emits the PRESENT-80 round keys in reverse order (K32 down to K1).
// On an accepted start the user key is run forward 31 steps to reach K32,
// then each accepted output steps the register backwards with the inverse
// schedule, so no key storage beyond one register is needed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of inv_key_sequencer_if (start/key in,
//                out_valid/out_ready/out_key/out_round stream, busy, done)
module inv_key_sequencer
  import present_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  inv_key_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [RND_W-1:0]  cnt_q, cnt_d;
  logic [RND_W:0]    round_q, round_d;
  logic              done_q, done_d;

  logic [KEY_W-1:0]  fwd_key;
  logic [KEY_W-1:0]  inv_key;
  logic [RND_W-1:0]  inv_rnd;

  // Going from round r to r-1 undoes the forward step that used counter r-1.
  assign inv_rnd = RND_W'(round_q - 1'b1);

  key_schedule u_key_schedule (
    .r (fwd_key),
    .x (key_q),
    .i (cnt_q)
  );

  inv_key_schedule u_inv_key_schedule (
    .r (inv_key),
    .x (key_q),
    .i (inv_rnd)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A start landing on the done cycle is dropped.
        if (bus.start && !done_q) begin
          key_d   = bus.key;
          cnt_d   = RND_W'(1);
          state_d = StFwd;
        end
      end
      StFwd: begin
        key_d = fwd_key;
        if (cnt_q == RND_W'(NUM_STEPS)) begin
          // Counter holds at its last value instead of wrapping to zero.
          round_d = (RND_W + 1)'(NUM_STEPS + 1);
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (round_q == (RND_W + 1)'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            key_d   = inv_key;
            round_d = round_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_key   = key_q[KEY_W-1:KEY_W-RKEY_W];
  assign bus.out_round = round_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_inv_key_sequencer.sv
// Self-checking bench for inv_key_sequencer and its two schedule step modules.
// Expected round keys come from a forward-only reference model (shift/or
// rotation plus a nibble lookup table) whose keys are played back in reverse.
module tb_inv_key_sequencer;
  import present_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_key_sequencer_if bus ();

  inv_key_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [79:0] ks_x, ks_r, iks_x, iks_r;
  logic [4:0]  ks_i, iks_i;

  key_schedule u_ks (
    .r (ks_r),
    .x (ks_x),
    .i (ks_i)
  );

  inv_key_schedule u_iks (
    .r (iks_r),
    .x (iks_x),
    .i (iks_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] golden [32];

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_sbox(input logic [3:0] v);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[63 - 4 * int'(v) -: 4];
  endfunction

  function automatic logic [79:0] model_f(input logic [79:0] k, input logic [4:0] i);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = model_sbox(t[79:76]);
    t[19:15] = t[19:15] ^ i;
    return t;
  endfunction

  // golden[n] is the round key presented n-th, i.e. K(32-n)[79:16].
  task automatic build_golden(input logic [79:0] k);
    logic [79:0] ks [33];
    ks[1] = k;
    for (int i = 1; i <= 31; i++) ks[i+1] = model_f(ks[i], 5'(i));
    for (int n = 0; n < 32; n++) golden[n] = ks[32-n][79:16];
  endtask

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic run_seq(input string name, input logic [79:0] k, input bit stall,
                         input bit poke, input int rst_round);
    int lat;
    int idx;
    int guard;
    bit rdy;
    logic [79:0] other;
    other = rand80();
    build_golden(k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = ~k;
    check_eq({name, " busy_after_accept"}, 80'(bus.busy), 80'd1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      bus.start = poke && (lat == 10);
      bus.key   = other;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check_eq({name, " first_valid_latency"}, 80'(lat), 80'd31);
    idx = 0;
    guard = 0;
    while (idx < 32 && guard < 2000) begin
      check_eq($sformatf("%s valid r%0d", name, 32 - idx), 80'(bus.out_valid), 80'd1);
      check_eq($sformatf("%s round r%0d", name, 32 - idx), 80'(bus.out_round), 80'(32 - idx));
      check_eq($sformatf("%s key r%0d", name, 32 - idx), 80'(bus.out_key), 80'(golden[idx]));
      check_eq($sformatf("%s done_low r%0d", name, 32 - idx), 80'(bus.done), 80'd0);
      if (rst_round != 0 && (32 - idx) == rst_round) begin
        rst_n = 1'b0;
        #1;
        check_eq({name, " rst valid"}, 80'(bus.out_valid), 80'd0);
        check_eq({name, " rst key"}, 80'(bus.out_key), 80'd0);
        check_eq({name, " rst round"}, 80'(bus.out_round), 80'd0);
        check_eq({name, " rst busy"}, 80'(bus.busy), 80'd0);
        check_eq({name, " rst done"}, 80'(bus.done), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check_eq({name, " post_rst valid"}, 80'(bus.out_valid), 80'd0);
          check_eq({name, " post_rst busy"}, 80'(bus.busy), 80'd0);
        end
        return;
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      bus.start = poke && (idx == 5);
      bus.key   = other;
      @(negedge clk);
      guard++;
      if (rdy) idx++;
    end
    bus.start = 1'b0;
    check_eq({name, " emitted_count"}, 80'(idx), 80'd32);
    check_eq({name, " done_pulse"}, 80'(bus.done), 80'd1);
    check_eq({name, " idle_after_last"}, 80'(bus.busy), 80'd0);
    check_eq({name, " valid_after_last"}, 80'(bus.out_valid), 80'd0);
    // A start on the done cycle must not be taken.
    bus.start = poke;
    bus.key   = other;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq({name, " done_cleared"}, 80'(bus.done), 80'd0);
    check_eq({name, " still_idle"}, 80'(bus.busy), 80'd0);
  endtask

  initial begin
    logic [79:0] x;
    logic [4:0]  i;
    bus.start     = 1'b0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #2;
    check_eq("reset busy", 80'(bus.busy), 80'd0);
    check_eq("reset valid", 80'(bus.out_valid), 80'd0);
    check_eq("reset done", 80'(bus.done), 80'd0);
    check_eq("reset key", 80'(bus.out_key), 80'd0);
    check_eq("reset round", 80'(bus.out_round), 80'd0);

    ks_x  = '0;
    ks_i  = 5'd1;
    iks_x = 80'hC0000000000000008000;
    iks_i = 5'd1;
    #1;
    check_eq("unit fwd_zero", ks_r, 80'hC0000000000000008000);
    check_eq("unit inv_directed", iks_r, 80'd0);
    for (int n = 0; n < 8; n++) begin
      x     = rand80();
      i     = 5'($urandom_range(1, 31));
      ks_x  = x;
      ks_i  = i;
      iks_x = model_f(x, i);
      iks_i = i;
      #1;
      check_eq($sformatf("unit fwd_rand%0d", n), ks_r, model_f(x, i));
      check_eq($sformatf("unit inv_rand%0d", n), iks_r, x);
    end

    @(negedge clk);
    rst_n = 1'b1;
    run_seq("zero", 80'd0, 1'b0, 1'b0, 0);
    run_seq("stall", 80'h8BA27A0EB8783AC96D59, 1'b1, 1'b0, 0);
    run_seq("poke", 80'h8BA27A0EB8783AC96D59, 1'b1, 1'b1, 0);
    run_seq("rst", rand80(), 1'b0, 1'b0, 17);
    run_seq("ones", 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 0);
    run_seq("rand", rand80(), 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_sequencer.md
INV_KEY_SEQUENCER -- requirements
Module: inv_key_sequencer

Interface
REQ-001 The block SHALL expose these parameters: none; all widths are fixed by the shared package.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a sequence, sampled only in IDLE.
REQ-005 The block SHALL have port key, input, 80 bits: the user key K1, captured on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 The block SHALL have port out_valid, output, 1 bit: a round key is presented.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the presented round key.
REQ-009 The block SHALL have port out_key, output, 64 bits: the presented round key, equal to key-register bits 79:16.
REQ-010 The block SHALL have port out_round, output, 6 bits: the round index of out_key, 32 down to 1.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse after round key 1 is accepted.

Function
REQ-012 The block SHALL implement the PRESENT-80 key schedule.
- Forward step f(K,i): rotate left 61; S-box on bits 79:76; bits 19:15 ^= i.
- Inverse step g(K,i): bits 19:15 ^= i; inverse S-box on bits 79:76; rotate right 61.
REQ-013 The FSM SHALL have exactly the states IDLE, FWD and EMIT.
REQ-014 In IDLE, start=1 SHALL load key into the state register, set the counter to 1 and move to FWD.
REQ-015 In FWD, each cycle SHALL apply state<=f(state,cnt) and cnt<=cnt+1.
REQ-016 In the cycle that applies cnt=31, FWD SHALL move to EMIT with round<=32 (K32 held).
REQ-017 out_valid SHALL be high exactly while in EMIT; the first out_valid SHALL occur 31 cycles after the accepting edge.
REQ-018 In EMIT, out_key and out_round SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 In EMIT, out_valid&out_ready with round>1 SHALL apply state<=g(state,round-1) and round<=round-1; the next key is valid the following cycle.
REQ-020 In EMIT, out_valid&out_ready with round=1 SHALL return to IDLE and pulse done for one cycle.
REQ-021 With out_ready held high, the block SHALL deliver one key per cycle, 32 in total.
REQ-022 start while busy SHALL be ignored, and key SHALL NOT be re-sampled.
REQ-023 start coincident with the done cycle SHALL be ignored; a new start is accepted from the next IDLE cycle.
REQ-024 The 5-bit counter and 6-bit round values SHALL never wrap; counter values 0 and 32 SHALL be unreachable in FWD.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, state=0, cnt=0, round=0, busy=0, out_valid=0, done=0, out_key=0 and out_round=0.
REQ-026 Reset asserted mid-FWD or mid-EMIT SHALL abandon the sequence with no further outputs; the first start after release SHALL begin afresh.

Structure
REQ-027 Package present_pkg SHALL hold KEY_W=80, RKEY_W=64, RND_W=5, NUM_STEPS=31, the S-box and inverse S-box tables, and the state enum.
REQ-028 The forward step SHALL instantiate the team's existing combinational key_schedule module.
REQ-029 The inverse step SHALL be a new combinational sub-module, inv_key_schedule (ports r, x, i).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- inv_key_schedule unit: x=C0000000000000008000, i=01 -> r=00000000000000000000. Also: key_schedule(x=0,i=1) -> C0000000000000008000.
- key=0, start pulse, out_ready=1: first out_valid 31 cycles after accept with out_round=32; then 32 consecutive keys with out_round 32..1. Each key SHALL match a golden model of forward-generated keys in reverse order. done SHALL pulse once.
- key=8BA27A0EB8783AC96D59, out_ready toggled pseudo-randomly: the key sequence is identical to the no-stall run, and out_key is stable across every stall cycle.
- start re-pulsed during FWD and during EMIT with a different key: the output sequence is unaffected.
- rst_n pulsed low at round 17 in EMIT: outputs are zero immediately. A restart with key FFFFFFFFFFFFFFFFFFFF SHALL produce the full correct 32-key sequence.
